// File: rtl/rate_step_counter.sv
// Programmable-rate step counter: prescaler divides clk by div, each terminal count advances count by step.
// Latency: registered outputs only; first tick lands div_eff enabled cycles after reset release.
// Backpressure: none; en low freezes all state and the period stretches by the paused cycles.
//
// Ports:
//   clk   - clock, all state on rising edge
//   rst   - synchronous active-high reset (overrides en)
//   en    - advance enable
//   div   - prescale divisor, 0 treated as 1 (taken into a shadow at terminal count / reset)
//   step  - unsigned increment per tick
//   mode  - 00 wrap, 01 saturate, 10 bounce, 11 wrap
//   count - registered count value
//   tick  - one-cycle pulse in the cycle a new count appears
//   dir   - 0 counting up, 1 counting down (bounce only)
module rate_step_counter #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [WIDTH-1:0]     step,
  input  logic [1:0]           mode,
  output logic [WIDTH-1:0]     count,
  output logic                 tick,
  output logic                 dir
);

  localparam logic [WIDTH:0] MAX_EXT = {1'b0, {WIDTH{1'b1}}};

  logic [DIV_WIDTH-1:0] pre;
  logic [DIV_WIDTH-1:0] div_sh;
  logic [DIV_WIDTH-1:0] div_eff;
  logic                 terminal;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     next_count;
  logic                 next_dir;

  // The divisor is only taken from the shadow, so a div change mid-period
  // never shortens the period already in progress.
  assign div_eff  = (div_sh == '0) ? DIV_WIDTH'(1) : div_sh;
  assign terminal = (pre == div_eff - DIV_WIDTH'(1));

  // One extra bit on the sum so the saturate/bounce limits see the carry.
  assign sum = {1'b0, count} + {1'b0, step};

  always_comb begin
    next_count = count;
    next_dir   = 1'b0;
    case (mode)
      2'b01: begin
        next_count = (sum > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : sum[WIDTH-1:0];
      end
      2'b10: begin
        if (!dir) begin
          if (sum >= MAX_EXT) begin
            next_count = MAX_EXT[WIDTH-1:0];
            next_dir   = 1'b1;
          end else begin
            next_count = sum[WIDTH-1:0];
            next_dir   = 1'b0;
          end
        end else begin
          if (count <= step) begin
            next_count = '0;
            next_dir   = 1'b0;
          end else begin
            next_count = count - step;
            next_dir   = 1'b1;
          end
        end
      end
      default: begin
        // Wrap (and the reserved code): leaving bounce always restarts upward.
        next_count = sum[WIDTH-1:0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre    <= '0;
      div_sh <= div;
      count  <= '0;
      tick   <= 1'b0;
      dir    <= 1'b0;
    end else if (en) begin
      if (terminal) begin
        pre    <= '0;
        div_sh <= div;
        count  <= next_count;
        dir    <= next_dir;
        tick   <= 1'b1;
      end else begin
        pre  <= pre + DIV_WIDTH'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rate_step_counter.sv
module tb_rate_step_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] div;
  logic [7:0]  step;
  logic [1:0]  mode;
  logic [7:0]  count;
  logic        tick;
  logic        dir;

  rate_step_counter #(.WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .div   (div),
    .step  (step),
    .mode  (mode),
    .count (count),
    .tick  (tick),
    .dir   (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] val;   // {count, tick, dir}
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Expected outputs are queued with the stimulus, then compared once the
  // DUT has taken the edge (sampled 1 time unit after it).
  task automatic cycle_chk(input logic [7:0] c, input logic t, input logic d, input string tag);
    exp_t e;
    exp_t got;
    logic [9:0] obs;
    e.val = {c, t, d};
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    obs = {count, tick, dir};
    n_total++;
    assert (obs === got.val) n_pass++;
    else $error("FAIL %s: observed count=%0d tick=%0d dir=%0d, expected count=%0d tick=%0d dir=%0d",
                got.tag, obs[9:2], obs[1], obs[0], got.val[9:2], got.val[1], got.val[0]);
  endtask

  task automatic do_reset(input logic [15:0] d, input string tag);
    rst = 1'b1;
    div = d;
    cycle_chk(8'd0, 1'b0, 1'b0, tag);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    div  = 16'd1;
    step = 8'd1;
    mode = 2'b00;
    #1;

    // Reset state
    do_reset(16'd1, "reset");

    // 1: div=1 wrap, tick every cycle, count rolls over 255 -> 0
    en = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      cycle_chk(8'(i % 256), 1'b1, 1'b0, "wrap_div1");
    end

    // 2: div=4, tick on every 4th cycle
    en = 1'b0;
    do_reset(16'd4, "reset_div4");
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      for (int j = 0; j < 3; j++) cycle_chk(8'(k - 1), 1'b0, 1'b0, "div4_wait");
      cycle_chk(8'(k), 1'b1, 1'b0, "div4_tick");
    end
    // pause 3 cycles mid-period: period becomes 7 cycles
    cycle_chk(8'd3, 1'b0, 1'b0, "pause_pre");
    en = 1'b0;
    for (int j = 0; j < 3; j++) cycle_chk(8'd3, 1'b0, 1'b0, "pause_hold");
    en = 1'b1;
    cycle_chk(8'd3, 1'b0, 1'b0, "pause_post");
    cycle_chk(8'd3, 1'b0, 1'b0, "pause_post");
    cycle_chk(8'd4, 1'b1, 1'b0, "pause_tick");

    // 3: div change one cycle after a tick does not truncate the period
    cycle_chk(8'd4, 1'b0, 1'b0, "divchg_a");
    div = 16'd2;
    cycle_chk(8'd4, 1'b0, 1'b0, "divchg_b");
    cycle_chk(8'd4, 1'b0, 1'b0, "divchg_c");
    cycle_chk(8'd5, 1'b1, 1'b0, "divchg_tick4");
    cycle_chk(8'd5, 1'b0, 1'b0, "div2_wait");
    cycle_chk(8'd6, 1'b1, 1'b0, "div2_tick");
    cycle_chk(8'd6, 1'b0, 1'b0, "div2_wait");
    cycle_chk(8'd7, 1'b1, 1'b0, "div2_tick");

    // 4: saturate
    en = 1'b0;
    do_reset(16'd1, "reset_sat");
    en   = 1'b1;
    mode = 2'b01;
    step = 8'd100;
    cycle_chk(8'd100, 1'b1, 1'b0, "sat_100");
    cycle_chk(8'd200, 1'b1, 1'b0, "sat_200");
    cycle_chk(8'd255, 1'b1, 1'b0, "sat_255");
    cycle_chk(8'd255, 1'b1, 1'b0, "sat_hold");
    cycle_chk(8'd255, 1'b1, 1'b0, "sat_hold");

    // 5: bounce / triangle
    en = 1'b0;
    do_reset(16'd1, "reset_bounce");
    en   = 1'b1;
    mode = 2'b10;
    cycle_chk(8'd100, 1'b1, 1'b0, "bnc_100");
    cycle_chk(8'd200, 1'b1, 1'b0, "bnc_200");
    cycle_chk(8'd255, 1'b1, 1'b1, "bnc_top");
    cycle_chk(8'd155, 1'b1, 1'b1, "bnc_155");
    cycle_chk(8'd55,  1'b1, 1'b1, "bnc_55");
    cycle_chk(8'd0,   1'b1, 1'b0, "bnc_bottom");
    cycle_chk(8'd100, 1'b1, 1'b0, "bnc_up100");
    cycle_chk(8'd200, 1'b1, 1'b0, "bnc_up200");
    cycle_chk(8'd255, 1'b1, 1'b1, "bnc_top2");
    // reserved mode acts as wrap and forces dir back to up
    mode = 2'b11;
    cycle_chk(8'd99,  1'b1, 1'b0, "mode3_wrap");
    cycle_chk(8'd199, 1'b1, 1'b0, "mode3_wrap2");
    // step=0 holds count but still ticks
    step = 8'd0;
    cycle_chk(8'd199, 1'b1, 1'b0, "step0_hold");
    cycle_chk(8'd199, 1'b1, 1'b0, "step0_hold");

    // 6: reset mid-period with en high, div=3
    mode = 2'b00;
    step = 8'd1;
    en   = 1'b0;
    do_reset(16'd3, "reset_div3");
    en = 1'b1;
    cycle_chk(8'd0, 1'b0, 1'b0, "div3_wait");
    cycle_chk(8'd0, 1'b0, 1'b0, "div3_wait");
    cycle_chk(8'd1, 1'b1, 1'b0, "div3_tick");
    cycle_chk(8'd1, 1'b0, 1'b0, "div3_mid");
    do_reset(16'd3, "rst_midperiod");
    cycle_chk(8'd0, 1'b0, 1'b0, "rel_wait");
    cycle_chk(8'd0, 1'b0, 1'b0, "rel_wait");
    cycle_chk(8'd1, 1'b1, 1'b0, "rel_tick3");

    // div=0 behaves as div=1
    do_reset(16'd0, "reset_div0");
    cycle_chk(8'd1, 1'b1, 1'b0, "div0_tick");
    cycle_chk(8'd2, 1'b1, 1'b0, "div0_tick");
    cycle_chk(8'd3, 1'b1, 1'b0, "div0_tick");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
